// File: rtl/integral_image_stream_builder.sv
// Streaming integral-image builder: one integral word per raster-order pixel, with 1-cycle latency.
// Optional frame-start sync (pix_sof/sof_err) is enabled by defining INTEGRAL_IMAGE_SOF_SYNC_EN.
module integral_image_stream_builder #(
  parameter int PIX_WIDTH = 8,
  parameter int WORD_SIZE = 32,
  parameter int IMG_COLS  = 24,
  parameter int IMG_ROWS  = 24
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [PIX_WIDTH-1:0] pix,
  input  logic                 pix_ready,
  output logic                 pix_wanted,
`ifdef INTEGRAL_IMAGE_SOF_SYNC_EN
  input  logic                 pix_sof,
  output logic                 sof_err,
`endif
  output logic [WORD_SIZE-1:0] data,
  output logic                 data_ready,
  input  logic                 data_wanted,
  output logic                 frame_done
);
  // state | meaning
  // EMPTY | output register holds no word (data_ready=0)
  // FULL  | output register holds a word awaiting acceptance (data_ready=1)
  localparam int CW = (IMG_COLS > 1) ? $clog2(IMG_COLS) : 1;
  localparam int RW = (IMG_ROWS > 1) ? $clog2(IMG_ROWS) : 1;

  typedef enum logic {EMPTY, FULL} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]        col, col_eff;
  logic [RW-1:0]        row, row_eff;
  logic [WORD_SIZE-1:0] rowsum, rowsum_eff, above, word, pix_ext;
  logic [WORD_SIZE-1:0] line_buf [IMG_COLS];
  logic                 last, in_xfer, out_xfer, sof_hit, col_wrap, row_wrap;

`ifdef INTEGRAL_IMAGE_SOF_SYNC_EN
  assign sof_hit = pix_sof;
`else
  assign sof_hit = 1'b0;
`endif

  // A start-of-frame pixel is placed at (0,0) regardless of the counters.
  always_comb begin
    col_eff    = sof_hit ? '0 : col;
    row_eff    = sof_hit ? '0 : row;
    rowsum_eff = sof_hit ? '0 : rowsum;
    pix_ext    = WORD_SIZE'(pix);
    above      = (row_eff == '0) ? '0 : line_buf[col_eff];
    word       = above + rowsum_eff + pix_ext;
    col_wrap   = (col_eff == CW'(IMG_COLS - 1));
    row_wrap   = (row_eff == RW'(IMG_ROWS - 1));
  end

  always_comb begin
    state_nxt  = state;
    data_ready = (state == FULL);
    pix_wanted = resetn && (!data_ready || data_wanted);
    in_xfer    = pix_ready && pix_wanted;
    out_xfer   = data_ready && data_wanted;
    case (state)
      EMPTY:   if (in_xfer) state_nxt = FULL;
      FULL:    if (out_xfer && !in_xfer) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= EMPTY;
      data       <= '0;
      col        <= '0;
      row        <= '0;
      rowsum     <= '0;
      last       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame_done <= out_xfer && last;
      if (in_xfer) begin
        data   <= word;
        last   <= col_wrap && row_wrap;
        col    <= col_wrap ? '0 : col_eff + CW'(1);
        rowsum <= col_wrap ? '0 : rowsum_eff + pix_ext;
        if (col_wrap) row <= row_wrap ? '0 : row_eff + RW'(1);
        else          row <= row_eff;
      end
    end
  end

  // Line buffer is never cleared; row 0 ignores it through the select above.
  always_ff @(posedge clk) begin
    if (in_xfer) line_buf[col_eff] <= word;
  end

`ifdef INTEGRAL_IMAGE_SOF_SYNC_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                                      sof_err <= 1'b0;
    else if (in_xfer && pix_sof && (col != '0 || row != '0)) sof_err <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_integral_image_stream_builder.sv
// Scoreboard bench for integral_image_stream_builder on a small 4x3 image with a narrow word
// so modulo wrap is exercised; pix_sof/sof_err are covered when INTEGRAL_IMAGE_SOF_SYNC_EN is set.
module tb_integral_image_stream_builder;
  localparam int PW = 8;
  localparam int W  = 11;
  localparam int C  = 4;
  localparam int R  = 3;
  localparam longint MASK = (64'd1 << W) - 1;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [PW-1:0] pix = '0;
  logic          pix_ready = 1'b0;
  logic          pix_wanted;
  logic [W-1:0]  data;
  logic          data_ready;
  logic          data_wanted;
  logic          frame_done;
`ifdef INTEGRAL_IMAGE_SOF_SYNC_EN
  logic          pix_sof = 1'b0;
  logic          sof_err;
`endif

  integral_image_stream_builder #(.PIX_WIDTH(PW), .WORD_SIZE(W), .IMG_COLS(C), .IMG_ROWS(R)) dut (
    .clk(clk), .resetn(resetn), .pix(pix), .pix_ready(pix_ready), .pix_wanted(pix_wanted),
`ifdef INTEGRAL_IMAGE_SOF_SYNC_EN
    .pix_sof(pix_sof), .sof_err(sof_err),
`endif
    .data(data), .data_ready(data_ready), .data_wanted(data_wanted), .frame_done(frame_done));

  always #5 clk = ~clk;

  typedef struct { longint word; bit last; } exp_t;
  exp_t   exp_q[$];
  int     errors = 0;
  int     checks = 0;
  int     fr[R][C];
  int     mx = 0, my = 0;
  bit     exp_sof_err = 1'b0;
  int     bp_mode = 0;
  int     cyc = 0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // Reference: brute-force rectangle sum over the current frame's pixels.
  task automatic model_accept(input int p, input bit sof);
    longint s = 0;
    exp_t e;
    if (sof) begin
      if (mx != 0 || my != 0) exp_sof_err = 1'b1;
      mx = 0; my = 0;
    end
    fr[my][mx] = p;
    for (int j = 0; j <= my; j++)
      for (int i = 0; i <= mx; i++) s += fr[j][i];
    e.word = s & MASK;
    e.last = (mx == C - 1) && (my == R - 1);
    exp_q.push_back(e);
    mx++;
    if (mx == C) begin
      mx = 0; my++;
      if (my == R) my = 0;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_pixel(input int p, input bit sof);
    bit acc = 1'b0;
    pix = PW'(p);
    pix_ready = 1'b1;
`ifdef INTEGRAL_IMAGE_SOF_SYNC_EN
    pix_sof = sof;
`endif
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge clk);
      if (pix_wanted) begin
        model_accept(p, sof);
        acc = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!acc) check("pix_accept_timeout", 0, 1);
    pix_ready = 1'b0;
`ifdef INTEGRAL_IMAGE_SOF_SYNC_EN
    pix_sof = 1'b0;
    check("sof_err", sof_err, exp_sof_err);
`endif
  endtask

  task automatic send_frame(input int kind, input bit gaps);
    int p;
    for (int k = 0; k < C * R; k++) begin
      p = (kind == 0) ? 1 : (kind == 1) ? 255 : int'($urandom_range(0, 255));
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send_pixel(p, 1'b0);
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 500 && exp_q.size() != 0; t++) @(posedge clk);
    check("drain_queue_empty", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    data_wanted = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      case (bp_mode)
        0:       data_wanted = 1'b1;
        1:       data_wanted = (cyc % 3 == 0);
        2:       data_wanted = ($urandom_range(0, 3) != 0);
        default: data_wanted = 1'b0;
      endcase
    end
  end

  initial begin
    bit          fd_exp = 1'b0;
    bit          held = 1'b0;
    logic [W-1:0] held_data = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        fd_exp = 1'b0;
        held = 1'b0;
      end else begin
        check("frame_done", frame_done, fd_exp);
        fd_exp = 1'b0;
        if (held) begin
          check("hold_data_ready", data_ready, 1);
          check("hold_data", data, held_data);
        end
        held = 1'b0;
        if (data_ready && data_wanted) begin
          check("word_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("data", data, e.word);
            fd_exp = e.last;
          end
        end else if (data_ready) begin
          check("pix_wanted_stall", pix_wanted, 0);
          held = 1'b1;
          held_data = data;
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_data_ready", data_ready, 0);
    check("rst_data", data, 0);
    check("rst_pix_wanted", pix_wanted, 0);
    check("rst_frame_done", frame_done, 0);
    resetn = 1'b1;
    #1;
    check("post_rst_pix_wanted", pix_wanted, 1);
    @(posedge clk);
    #1;

    bp_mode = 0;
    send_frame(0, 1'b0);
    drain();

    bp_mode = 1;
    send_frame(0, 1'b0);
    drain();

    bp_mode = 0;
    send_frame(1, 1'b0);
    send_frame(1, 1'b0);
    drain();

    bp_mode = 2;
    for (int f = 0; f < 4; f++) send_frame(2, 1'b1);
    drain();

    // Mid-frame reset with a word still pending.
    bp_mode = 0;
    for (int k = 0; k < 6; k++) send_pixel(k, 1'b0);
    bp_mode = 3;
    @(posedge clk);
    #1;
    check("pre_rst_pending", data_ready, 1);
    resetn = 1'b0;
    #1;
    check("mid_rst_data_ready", data_ready, 0);
    check("mid_rst_pix_wanted", pix_wanted, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    mx = 0; my = 0;
    bp_mode = 0;
    @(posedge clk);
    #1;
    for (int k = 5; k < 5 + C * R; k++) send_pixel(k, 1'b0);
    drain();

`ifdef INTEGRAL_IMAGE_SOF_SYNC_EN
    send_pixel(7, 1'b1);
    send_pixel(9, 1'b0);
    send_pixel(42, 1'b1);
    for (int k = 0; k < C * R - 1; k++) send_pixel(k + 3, 1'b0);
    drain();
    check("sof_err_sticky", sof_err, 1);
`endif

    check("final_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
